// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents:
//   state_e        - loader FSM state encoding (IDLE=0, RECV=1, WRITE=2, DONE=3)
//   BYTES_PER_WORD - bytes packed into one instruction word
//   WORD_W         - instruction word width in bits
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

endpackage : loader_pkg

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: big-endian byte-to-word shift register for the boot loader.
// The first byte of a word shifts all the way up to bits [31:24].
// Ports:
//   clk_i       - system clock
//   rst_ni      - synchronous active-low reset
//   clear_i     - drop any partial word and restart at byte 0
//   shift_i     - accept byte_i this cycle
//   byte_i      - incoming byte
//   word_o      - the word as it will look once byte_i has been shifted in
//   word_full_o - high when the byte being accepted completes a word
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [1:0]        cnt_q, cnt_d;

    // Next-state for the shift register and byte position.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = {WORD_W{1'b0}};
            cnt_d   = 2'd0;
        end else if (shift_i) begin
            shift_d = {shift_q[WORD_W-9:0], byte_i};
            cnt_d   = cnt_q + 2'd1;   // wraps to 0 after the 4th byte
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shift_q <= {WORD_W{1'b0}};
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Look-ahead word lets the loader register the finished word on the same
    // edge that accepts its last byte, so the write strobe follows one cycle later.
    assign word_o      = {shift_q[WORD_W-9:0], byte_i};
    assign word_full_o = shift_i & (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule : byte_packer

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader on the instruction-memory write port.
// Packs a valid/ready byte stream into big-endian 32-bit words, writes them to
// consecutive word addresses from 0, and holds the CPU in reset until the
// requested number of words has been written.
// Ports:
//   clk_i       - system clock, rising edge
//   rst_ni      - synchronous active-low reset
//   start_i     - one-cycle load request, honoured only in IDLE or DONE
//   len_i       - number of words to load (saturates at 2^ADDR_W)
//   in_valid_i  - byte-stream valid
//   in_data_i   - byte-stream data
//   in_ready_o  - loader takes a byte this cycle
//   im_we_o     - instruction-memory write strobe
//   im_addr_o   - instruction-memory word address
//   im_wdata_o  - instruction word
//   cpu_hold_o  - CPU reset request, 1 = held
//   busy_o      - load in progress
//   done_o      - last load completed, CPU released
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [WORD_W-1:0] im_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o
);

    import loader_pkg::*;

    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              clear_s;
    logic              accept_s;
    logic [WORD_W-1:0] pack_word_s;
    logic              pack_full_s;

    logic              in_ready_q, im_we_q, cpu_hold_q, busy_q, done_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [WORD_W-1:0] im_wdata_q;

    // in_ready_q is only ever set for RECV, so it doubles as the accept gate.
    assign accept_s = in_valid_i & in_ready_q;

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_s),
        .shift_i     (accept_s),
        .byte_i      (in_data_i),
        .word_o      (pack_word_s),
        .word_full_o (pack_full_s)
    );

    // Next-state logic for the FSM, latched length and word counter.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        clear_s    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    clear_s    = 1'b1;
                    word_cnt_d = CNT_ZERO;
                    if (len_i == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RECV;
                        len_d   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RECV: begin
                if (pack_full_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_WRITE: begin
                // Counter is one bit wider than the address so a full-memory
                // load reaches 2^ADDR_W instead of wrapping to 0.
                word_cnt_d = word_cnt_q + CNT_ONE;
                if (word_cnt_d == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched length and word counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            len_q      <= CNT_ZERO;
            word_cnt_q <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Output registers, decoded from the next state so each output changes on
    // the same edge as the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= {ADDR_W{1'b0}};
            im_wdata_q <= {WORD_W{1'b0}};
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= (state_d == ST_RECV);
            im_we_q    <= (state_d == ST_WRITE);
            cpu_hold_q <= (state_d != ST_DONE);
            busy_q     <= (state_d == ST_RECV) || (state_d == ST_WRITE);
            done_q     <= (state_d == ST_DONE);
            if ((state_q == ST_RECV) && (state_d == ST_WRITE)) begin
                im_addr_q  <= word_cnt_q[ADDR_W-1:0];
                im_wdata_q <= pack_word_s;
            end else begin
                im_addr_q  <= im_addr_q;
                im_wdata_q <= im_wdata_q;
            end
        end
    end

    assign in_ready_o = in_ready_q;
    assign im_we_o    = im_we_q;
    assign im_addr_o  = im_addr_q;
    assign im_wdata_o = im_wdata_q;
    assign cpu_hold_o = cpu_hold_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: reset, single word, gapped multi-word
// load with an ignored mid-load start, reset mid-load, len=0, reload from DONE
// and a saturated full-memory load.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    // Memory model fed by the write port, plus write bookkeeping.
    logic [31:0] mem [0:255];
    int          wr_cnt   = 0;
    int          rdy_viol = 0;
    logic [7:0]  last_addr = 8'd0;

    imem_loader #(.ADDR_W(8), .WORD_W(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .len_i      (len),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .im_we_o    (im_we),
        .im_addr_o  (im_addr),
        .im_wdata_o (im_wdata),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe mid-cycle.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            mem[im_addr] <= im_wdata;
            last_addr    <= im_addr;
            wr_cnt       <= wr_cnt + 1;
            if (in_ready !== 1'b0) rdy_viol <= rdy_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && n < 20) begin
            acc = (in_ready === 1'b1);
            step();
            n++;
        end
        chk("byte_accept", {63'd0, acc}, 64'd1);
        if (gap) begin
            in_valid = 1'b0;
            step();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        chk("done_wait", {63'd0, done}, 64'd1);
    endtask

    int base;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 9'd0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset held for two cycles
        step();
        step();
        chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_im_we",    {63'd0, im_we},    64'd0);
        chk("rst_done",     {63'd0, done},     64'd0);
        chk("rst_busy",     {63'd0, busy},     64'd0);
        chk("rst_im_addr",  {56'd0, im_addr},  64'd0);
        chk("rst_im_wdata", {32'd0, im_wdata}, 64'd0);
        rst_n = 1'b1;
        step();

        // Single word; a stray byte offered in IDLE must not be consumed
        base     = wr_cnt;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        start    = 1'b1;
        len      = 9'd1;
        step();
        start = 1'b0;
        chk("w1_busy",     {63'd0, busy},     64'd1);
        chk("w1_in_ready", {63'd0, in_ready}, 64'd1);
        chk("w1_hold",     {63'd0, cpu_hold}, 64'd1);
        send_word(32'h20080005, 1'b0);
        in_valid = 1'b0;
        chk("w1_we",       {63'd0, im_we},    64'd1);
        chk("w1_addr",     {56'd0, im_addr},  64'd0);
        chk("w1_wdata",    {32'd0, im_wdata}, 64'h20080005);
        chk("w1_rdy_wr",   {63'd0, in_ready}, 64'd0);
        chk("w1_done_pre", {63'd0, done},     64'd0);
        step();
        chk("w1_done",  {63'd0, done},     64'd1);
        chk("w1_hold0", {63'd0, cpu_hold}, 64'd0);
        chk("w1_we0",   {63'd0, im_we},    64'd0);
        chk("w1_busy0", {63'd0, busy},     64'd0);
        chk("w1_count", wr_cnt - base,     64'd1);

        // Reload from DONE: three gapped words, second start during RECV ignored
        base  = wr_cnt;
        start = 1'b1;
        len   = 9'd3;
        step();
        start = 1'b0;
        chk("rl_hold", {63'd0, cpu_hold}, 64'd1);
        chk("rl_done", {63'd0, done},     64'd0);
        send_byte(8'h11, 1'b0);
        in_valid = 1'b0;
        start    = 1'b1;
        len      = 9'd1;
        step();
        start = 1'b0;
        len   = 9'd3;
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_word(32'h55667788, 1'b1);
        send_word(32'h99AABBCC, 1'b1);
        wait_done(20);
        chk("w3_count", wr_cnt - base, 64'd3);
        chk("w3_mem0",  {32'd0, mem[0]}, 64'h11223344);
        chk("w3_mem1",  {32'd0, mem[1]}, 64'h55667788);
        chk("w3_mem2",  {32'd0, mem[2]}, 64'h99AABBCC);
        chk("w3_rdy_viol", rdy_viol, 64'd0);
        chk("w3_hold0", {63'd0, cpu_hold}, 64'd0);

        // Reset after two bytes of the first word of a new load
        base  = wr_cnt;
        start = 1'b1;
        len   = 9'd2;
        step();
        start = 1'b0;
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mr_we",    {63'd0, im_we},    64'd0);
        chk("mr_busy",  {63'd0, busy},     64'd0);
        chk("mr_rdy",   {63'd0, in_ready}, 64'd0);
        chk("mr_hold",  {63'd0, cpu_hold}, 64'd1);
        chk("mr_done",  {63'd0, done},     64'd0);
        step();
        chk("mr_idle_rdy", {63'd0, in_ready}, 64'd0);
        chk("mr_count", wr_cnt - base, 64'd0);

        // len=0 from IDLE: done one cycle later, no write
        start = 1'b1;
        len   = 9'd0;
        step();
        start = 1'b0;
        chk("l0_done", {63'd0, done},     64'd1);
        chk("l0_hold", {63'd0, cpu_hold}, 64'd0);
        chk("l0_busy", {63'd0, busy},     64'd0);
        step();
        chk("l0_count", wr_cnt - base, 64'd0);

        // Fresh single-word load after the aborted one
        start = 1'b1;
        len   = 9'd1;
        step();
        start = 1'b0;
        send_word(32'hDEADBEEF, 1'b0);
        in_valid = 1'b0;
        wait_done(5);
        chk("fr_count", wr_cnt - base, 64'd1);
        chk("fr_mem0",  {32'd0, mem[0]}, 64'hDEADBEEF);
        chk("fr_mem1",  {32'd0, mem[1]}, 64'h55667788);

        // Oversized len saturates to a full 256-word load without wrap
        base  = wr_cnt;
        start = 1'b1;
        len   = 9'h1FF;
        step();
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            send_word({i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3}, 1'b0);
        end
        in_valid = 1'b0;
        wait_done(5);
        chk("sat_count", wr_cnt - base, 64'd256);
        chk("sat_last",  {56'd0, last_addr}, 64'd255);
        chk("sat_mem0",  {32'd0, mem[0]},   64'h00FF5AC3);
        chk("sat_mem255", {32'd0, mem[255]}, 64'hFF00A5C3);
        chk("sat_hold0", {63'd0, cpu_hold}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_imem_loader
